// File: rtl/caliptra_prim_count_decoder.sv
// rtl/caliptra_prim_count_decoder.sv - observer-side decoder and fault monitor for the hardened counter action encoding

package caliptra_prim_count_pkg;
  // One-hot action encoding shared with the counter itself
  typedef enum logic [3:0] {
    Clr  = 4'h1,
    Set  = 4'h2,
    Incr = 4'h4,
    Decr = 4'h8
  } action_e;

  typedef logic [3:0] action_mask_t;
endpackage

module caliptra_prim_count_decoder
  import caliptra_prim_count_pkg::*;
#(
  parameter int unsigned            Width           = 8,
  parameter logic [Width-1:0]       ResetValue      = '0,
  parameter action_mask_t           PossibleActions = 4'hF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] cnt_i,
  input  logic [Width-1:0] set_val_i,
  input  logic [Width-1:0] step_i,
  output logic [3:0]       action_o,
  output logic             action_valid_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StTrack = 2'd1,
    StErr   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] prev_q, prev_d;
  logic [3:0]       action_q, action_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Expected next values for Incr/Decr, saturating like the counter does
  logic [Width:0]   incr_sum;
  logic [Width:0]   decr_diff;
  logic [Width-1:0] incr_exp;
  logic [Width-1:0] decr_exp;

  assign incr_sum  = {1'b0, prev_q} + {1'b0, step_i};
  assign decr_diff = {1'b0, prev_q} - {1'b0, step_i};
  assign incr_exp  = incr_sum[Width]  ? {Width{1'b1}} : incr_sum[Width-1:0];
  assign decr_exp  = decr_diff[Width] ? {Width{1'b0}} : decr_diff[Width-1:0];

  logic [3:0] dec_act;
  logic       illegal;
  logic       allowed;

  // Classify the observed transition; earlier matches take priority so that
  // ambiguous transitions (e.g. Decr saturating onto ResetValue) resolve to Clr
  always_comb begin
    dec_act = 4'h0;
    illegal = 1'b0;
    if (cnt_i == prev_q) begin
      dec_act = 4'h0;
    end else if (cnt_i == ResetValue) begin
      dec_act = Clr;
    end else if (cnt_i == set_val_i) begin
      dec_act = Set;
    end else if (cnt_i == incr_exp) begin
      dec_act = Incr;
    end else if (cnt_i == decr_exp) begin
      dec_act = Decr;
    end else begin
      illegal = 1'b1;
    end
  end

  // "No change" carries no action bit and is always acceptable
  assign allowed = (dec_act == 4'h0) || ((dec_act & PossibleActions) != 4'h0);

  // Next-state and registered-output logic; StErr is absorbing until reset
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    action_d = action_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StInit: begin
        if (en_i) begin
          prev_d = cnt_i;
          if (cnt_i == ResetValue) begin
            state_d  = StTrack;
            valid_d  = 1'b1;
            action_d = 4'h0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StTrack: begin
        if (en_i) begin
          prev_d = cnt_i;
          if (illegal || !allowed) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            valid_d  = 1'b1;
            action_d = dec_act;
          end
        end
      end
      StErr: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = StErr;
        err_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StInit;
      prev_q   <= ResetValue;
      action_q <= 4'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      action_q <= action_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign action_o       = action_q;
  assign action_valid_o = valid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_caliptra_prim_count_decoder.sv
// tb/tb_caliptra_prim_count_decoder.sv - scoreboard bench for caliptra_prim_count_decoder

module tb_caliptra_prim_count_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] cnt;
  logic [7:0] set_val;
  logic [7:0] step;

  logic [2:0][3:0] act_o;
  logic [2:0]      vld_o;
  logic [2:0]      err_o;

  always #5 clk = ~clk;

  // Three observers on the same counter, differing only in permitted actions
  caliptra_prim_count_decoder #(.Width(8), .ResetValue(8'h00), .PossibleActions(4'hF)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cnt_i(cnt), .set_val_i(set_val), .step_i(step),
    .action_o(act_o[0]), .action_valid_o(vld_o[0]), .err_o(err_o[0]));
  caliptra_prim_count_decoder #(.Width(8), .ResetValue(8'h00), .PossibleActions(4'h5)) dut_m5 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cnt_i(cnt), .set_val_i(set_val), .step_i(step),
    .action_o(act_o[1]), .action_valid_o(vld_o[1]), .err_o(err_o[1]));
  caliptra_prim_count_decoder #(.Width(8), .ResetValue(8'h00), .PossibleActions(4'h8)) dut_m8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cnt_i(cnt), .set_val_i(set_val), .step_i(step),
    .action_o(act_o[2]), .action_valid_o(vld_o[2]), .err_o(err_o[2]));

  typedef struct packed {
    logic [2:0][3:0] act;
    logic [2:0]      vld;
    logic [2:0]      err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: 0 = waiting for first sample, 1 = tracking, 2 = error
  int         m_mode[3];
  int         m_prev[3];
  logic [3:0] m_act[3];
  logic       m_vld[3];
  logic       m_err[3];
  int         cur;

  function automatic logic [3:0] mask_of(input int i);
    case (i)
      0: return 4'hF;
      1: return 4'h5;
      default: return 4'h8;
    endcase
  endfunction

  // Returns the one-hot action explaining prev->c, 0 for no change, -1 if none fits
  function automatic int decode(input int p, input int c, input int sv, input int st);
    int up, dn;
    up = p + st; if (up > 255) up = 255;
    dn = p - st; if (dn < 0)   dn = 0;
    if (c == p)  return 0;
    if (c == 0)  return 1;
    if (c == sv) return 2;
    if (c == up) return 4;
    if (c == dn) return 8;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input int c, input int sv, input int st);
    int d;
    for (int i = 0; i < 3; i++) begin
      m_vld[i] = 1'b0;
      if (!r) begin
        m_mode[i] = 0; m_prev[i] = 0; m_act[i] = 4'h0; m_err[i] = 1'b0;
      end else if (m_mode[i] == 2 || !e) begin
        // error is absorbing; disabled cycles change nothing
      end else if (m_mode[i] == 0) begin
        m_prev[i] = c;
        if (c == 0) begin
          m_mode[i] = 1; m_vld[i] = 1'b1; m_act[i] = 4'h0;
        end else begin
          m_mode[i] = 2; m_err[i] = 1'b1;
        end
      end else begin
        d = decode(m_prev[i], c, sv, st);
        m_prev[i] = c;
        if (d < 0 || (d != 0 && (4'(d) & mask_of(i)) == 4'h0)) begin
          m_mode[i] = 2; m_err[i] = 1'b1;
        end else begin
          m_vld[i] = 1'b1; m_act[i] = 4'(d);
        end
      end
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge
  task automatic cycle(input logic r, input logic e, input logic [7:0] c, input logic [7:0] sv, input logic [7:0] st);
    exp_t x;
    rst_n = r; en = e; cnt = c; set_val = sv; step = st;
    model_step(r, e, int'(c), int'(sv), int'(st));
    for (int i = 0; i < 3; i++) begin
      x.act[i] = m_act[i]; x.vld[i] = m_vld[i]; x.err[i] = m_err[i];
    end
    sb.push_back(x);
    if (!r) cur = 0; else if (e) cur = int'(c);
    @(negedge clk);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle
  always @(posedge clk) begin
    exp_t x;
    #1;
    cyc++;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (vld_o[i] !== x.vld[i]) begin
          errors++;
          $display("FAIL valid inst%0d cyc%0d: got %b want %b", i, cyc, vld_o[i], x.vld[i]);
        end
        checks++;
        if (err_o[i] !== x.err[i]) begin
          errors++;
          $display("FAIL err inst%0d cyc%0d: got %b want %b", i, cyc, err_o[i], x.err[i]);
        end
        checks++;
        if (act_o[i] !== x.act[i]) begin
          errors++;
          $display("FAIL action inst%0d cyc%0d: got %h want %h", i, cyc, act_o[i], x.act[i]);
        end
      end
    end
  end

  initial begin
    int         kind;
    logic [7:0] c, sv, st;
    rst_n = 1'b0; en = 1'b0; cnt = 8'h00; set_val = 8'h00; step = 8'h00; cur = 0;
    @(negedge clk);

    // Reset then three unit increments
    cycle(0, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h01, 8'h00, 8'h01);
    cycle(1, 1, 8'h02, 8'h00, 8'h01);
    cycle(1, 1, 8'h03, 8'h00, 8'h01);
    // Saturating increment, then Clr winning over a saturating decrement
    cycle(1, 1, 8'hFE, 8'hFE, 8'h01);
    cycle(1, 1, 8'hFF, 8'h00, 8'h04);
    cycle(1, 1, 8'h03, 8'h03, 8'h04);
    cycle(1, 1, 8'h00, 8'h00, 8'h08);
    // Set, legal continuation after errors elsewhere
    cycle(0, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h10, 8'h10, 8'h01);
    cycle(1, 1, 8'h55, 8'h55, 8'h01);
    cycle(1, 1, 8'h56, 8'h55, 8'h01);
    cycle(1, 1, 8'h57, 8'h55, 8'h01);
    // Illegal jump, error sticks, one-cycle reset recovers
    cycle(0, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h10, 8'h00, 8'h10);
    cycle(1, 1, 8'h20, 8'h00, 8'h01);
    cycle(1, 1, 8'h21, 8'h00, 8'h01);
    cycle(1, 1, 8'h22, 8'h00, 8'h01);
    cycle(0, 1, 8'h22, 8'h00, 8'h01);
    cycle(1, 1, 8'h00, 8'h00, 8'h01);
    // Non-reset first sample, then disabled cycles with moving input
    cycle(0, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 0, 8'h33, 8'h00, 8'h01);
    cycle(1, 1, 8'h07, 8'h00, 8'h01);
    cycle(1, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 0, 8'h01, 8'h00, 8'h01);
    // Disabled cycles while tracking hold the last pulse data
    cycle(0, 0, 8'h00, 8'h00, 8'h01);
    cycle(1, 1, 8'h00, 8'h00, 8'h02);
    cycle(1, 1, 8'h02, 8'h00, 8'h02);
    cycle(1, 0, 8'h99, 8'h00, 8'h02);
    cycle(1, 0, 8'h44, 8'h00, 8'h02);
    cycle(1, 1, 8'h00, 8'h00, 8'h05);
    // Zero step: any non-Clr/Set change is illegal
    cycle(1, 1, 8'h01, 8'h00, 8'h00);

    // Randomized mostly-legal traffic with periodic resets
    for (int n = 0; n < 600; n++) begin
      sv = 8'($urandom);
      st = 8'($urandom_range(0, 20));
      kind = $urandom_range(0, 9);
      case (kind)
        0:       c = 8'(cur);
        1:       c = 8'h00;
        2:       c = sv;
        3, 4:    c = (cur + int'(st) > 255) ? 8'hFF : 8'(cur + int'(st));
        5, 6:    c = (cur < int'(st)) ? 8'h00 : 8'(cur - int'(st));
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0)     cycle(0, 1'($urandom), c, sv, st);
      else if ($urandom_range(0, 4) == 0) cycle(1, 0, 8'($urandom), sv, st);
      else                                cycle(1, 1, c, sv, st);
    end

    cycle(1, 0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
